// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the MIPS32 pipeline registers: bubble constants
// and the set of actions a pipeline register can take in one cycle.
package cpu_defs;

    // Values written into a stage register to turn it into a bubble
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteDisable = 1'b0;

    // One action per cycle, listed in priority order
    typedef enum logic [1:0] {
        ACT_FLUSH  = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_PASS   = 2'd3
    } action_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with flush/stall handling, HI/LO fields,
// multi-cycle (madd/msub) partial-result feedback and a bubble counter.
module ex_mem_pipe
    import cpu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_ex,
    input  logic                stall_mem,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] ex_hilo_temp,
    input  logic [CNT_W-1:0]    ex_cnt,
    input  logic                clr_stat,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [2*DATA_W-1:0] hilo_temp_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [STAT_W-1:0]   bubble_cnt
);

    action_e             action;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   wd_q, wd_d;
    logic                wreg_q, wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                whilo_q, whilo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [2*DATA_W-1:0] temp_q, temp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Priority decode; stall_mem alone (never issued) falls into HOLD
    always_comb begin
        action = ACT_PASS;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (stall_mem) begin
            action = ACT_HOLD;
        end else if (stall_ex) begin
            action = ACT_BUBBLE;
        end
    end

    // Next-state of the MEM fields and the multi-cycle feedback registers
    always_comb begin
        valid_d = valid_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        temp_d  = temp_q;
        cnt_d   = cnt_q;
        if (action == ACT_FLUSH || action == ACT_BUBBLE) begin
            valid_d = WriteDisable;
            wd_d    = ADDR_W'(NOPRegAddr);
            wreg_d  = WriteDisable;
            wdata_d = DATA_W'(ZeroWord);
            whilo_d = WriteDisable;
            hi_d    = DATA_W'(ZeroWord);
            lo_d    = DATA_W'(ZeroWord);
        end
        case (action)
            ACT_FLUSH: begin
                temp_d = '0;
                cnt_d  = '0;
            end
            ACT_BUBBLE: begin
                // Keep the partial result so EX can continue next cycle
                temp_d = ex_hilo_temp;
                cnt_d  = ex_cnt;
            end
            ACT_PASS: begin
                valid_d = ex_valid;
                wd_d    = ex_wd;
                wreg_d  = ex_wreg;
                wdata_d = ex_wdata;
                whilo_d = ex_whilo;
                hi_d    = ex_hi;
                lo_d    = ex_lo;
                temp_d  = '0;
                cnt_d   = '0;
            end
            default: ;
        endcase
    end

    // Stage registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            temp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            temp_q  <= temp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only inserted bubbles are counted; flush cycles are not
    sat_counter #(.W(STAT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (action == ACT_BUBBLE),
        .clr_i (clr_stat),
        .cnt_o (bubble_cnt)
    );

    assign mem_valid   = valid_q;
    assign mem_wd      = wd_q;
    assign mem_wreg    = wreg_q;
    assign mem_wdata   = wdata_q;
    assign mem_whilo   = whilo_q;
    assign mem_hi      = hi_q;
    assign mem_lo      = lo_q;
    assign hilo_temp_o = temp_q;
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: a default-width instance and a STAT_W=2 instance
// share all inputs; a reference model pushes expected outputs to a queue.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_ex = 1'b0, stall_mem = 1'b0, flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0;
    logic        ex_whilo = 1'b0;
    logic [31:0] ex_hi = '0, ex_lo = '0;
    logic [63:0] ex_hilo_temp = '0;
    logic [1:0]  ex_cnt = '0;
    logic        clr_stat = 1'b0;

    logic        mem_valid, mem_wreg, mem_whilo;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_wreg, s_whilo;
    logic [4:0]  s_wd;
    logic [31:0] s_wdata, s_hi, s_lo;
    logic [63:0] s_temp;
    logic [1:0]  s_cnt;
    logic [1:0]  s_bub;

    typedef struct packed {
        logic        valid;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] temp;
        logic [1:0]  cnt;
        logic [15:0] bub;
        logic [1:0]  bub_s;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Clock
    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_temp(ex_hilo_temp),
        .ex_cnt(ex_cnt), .clr_stat(clr_stat),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    ex_mem_pipe #(.STAT_W(2)) dut_s (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_temp(ex_hilo_temp),
        .ex_cnt(ex_cnt), .clr_stat(clr_stat),
        .mem_valid(s_valid), .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata),
        .mem_whilo(s_whilo), .mem_hi(s_hi), .mem_lo(s_lo),
        .hilo_temp_o(s_temp), .cnt_o(s_cnt), .bubble_cnt(s_bub)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step, input exp_t e);
        check({step, ":mem_valid"}, 64'(mem_valid), 64'(e.valid));
        check({step, ":mem_wd"},    64'(mem_wd),    64'(e.wd));
        check({step, ":mem_wreg"},  64'(mem_wreg),  64'(e.wreg));
        check({step, ":mem_wdata"}, 64'(mem_wdata), 64'(e.wdata));
        check({step, ":mem_whilo"}, 64'(mem_whilo), 64'(e.whilo));
        check({step, ":mem_hi"},    64'(mem_hi),    64'(e.hi));
        check({step, ":mem_lo"},    64'(mem_lo),    64'(e.lo));
        check({step, ":hilo_temp"}, hilo_temp_o,    e.temp);
        check({step, ":cnt_o"},     64'(cnt_o),     64'(e.cnt));
        check({step, ":bubble_cnt"}, 64'(bubble_cnt), 64'(e.bub));
        check({step, ":s_wdata"},   64'(s_wdata),   64'(e.wdata));
        check({step, ":s_cnt"},     64'(s_cnt),     64'(e.cnt));
        check({step, ":s_bubble_cnt"}, 64'(s_bub),  64'(e.bub_s));
    endtask

    // Reference behaviour of one clock edge given the current inputs
    function automatic exp_t model_next(input exp_t c);
        exp_t n;
        n = c;
        if (flush) begin
            n.valid = 0; n.wd = 0; n.wreg = 0; n.wdata = 0; n.whilo = 0; n.hi = 0; n.lo = 0;
            n.temp = 0; n.cnt = 0;
        end else if (stall_mem) begin
            n = c;
        end else if (stall_ex) begin
            n.valid = 0; n.wd = 0; n.wreg = 0; n.wdata = 0; n.whilo = 0; n.hi = 0; n.lo = 0;
            n.temp = ex_hilo_temp; n.cnt = ex_cnt;
            if (c.bub < 16'hFFFF) n.bub = c.bub + 16'd1;
            if (c.bub_s < 2'd3) n.bub_s = c.bub_s + 2'd1;
        end else begin
            n.valid = ex_valid; n.wd = ex_wd; n.wreg = ex_wreg; n.wdata = ex_wdata;
            n.whilo = ex_whilo; n.hi = ex_hi; n.lo = ex_lo; n.temp = 0; n.cnt = 0;
        end
        if (clr_stat) begin
            n.bub = 0;
            n.bub_s = 0;
        end
        return n;
    endfunction

    // Driver: one clock with the inputs currently applied, then score
    task automatic step(input string tag);
        exp_t e;
        m = model_next(m);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_all(tag, e);
    endtask

    task automatic drive_pass(input logic v, input logic [4:0] wd, input logic wr,
                              input logic [31:0] wdata, input logic wh,
                              input logic [31:0] hi, input logic [31:0] lo);
        flush = 0; stall_mem = 0; stall_ex = 0; clr_stat = 0;
        ex_valid = v; ex_wd = wd; ex_wreg = wr; ex_wdata = wdata;
        ex_whilo = wh; ex_hi = hi; ex_lo = lo;
    endtask

    task automatic expect_reset(input string tag);
        m = '0;
        exp_q.push_back(m);
        check_all(tag, exp_q.pop_front());
    endtask

    initial begin
        exp_t e0;
        // Reset at start, checked before the first edge
        #1 rst = 1'b1;
        #1 expect_reset("reset_init");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ex_hilo_temp = 64'hFFFF_0000_FFFF_0000; ex_cnt = 2'd3;

        // PASS
        drive_pass(1'b1, 5'd3, 1'b1, 32'hDEADBEEF, 1'b1, 32'h1, 32'h2);
        step("pass");

        // BUBBLE for madd, two cycles
        stall_ex = 1; ex_hilo_temp = 64'h0000_0001_0000_0002; ex_cnt = 2'd1;
        ex_wdata = 32'h1111_2222;
        step("bubble1");
        step("bubble2");
        check("bubble_cnt_is_2", 64'(bubble_cnt), 64'd2);
        check("bubble_temp", hilo_temp_o, 64'h0000_0001_0000_0002);
        drive_pass(1'b1, 5'd7, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h3, 32'h4);
        step("pass_after_madd");
        check("cnt_back_to_0", 64'(cnt_o), 64'd0);

        // HOLD
        drive_pass(1'b1, 5'd9, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h55, 32'h66);
        step("pass_a5");
        stall_ex = 1; stall_mem = 1;
        for (int i = 0; i < 3; i++) begin
            ex_wd = 5'(i + 20); ex_wdata = $urandom; ex_hi = $urandom; ex_lo = $urandom;
            ex_hilo_temp = {$urandom, $urandom}; ex_cnt = 2'(i);
            step("hold");
        end
        check("hold_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
        stall_ex = 0;
        step("hold_stall_mem_only");

        // FLUSH priority over BUBBLE
        flush = 1; stall_ex = 1; stall_mem = 0; ex_cnt = 2'd2;
        step("flush_over_bubble");
        // FLUSH priority over HOLD
        drive_pass(1'b1, 5'd1, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0, 32'h0);
        step("pass_pre_flush");
        flush = 1; stall_mem = 1; stall_ex = 1;
        step("flush_over_hold");

        // Saturation on the 2-bit counter, clear beats increment
        drive_pass(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        clr_stat = 1;
        step("clr_stat");
        clr_stat = 0; stall_ex = 1;
        for (int i = 0; i < 5; i++) begin
            ex_hilo_temp = {$urandom, $urandom}; ex_cnt = 2'($urandom_range(0, 3));
            step("sat_bubble");
        end
        check("sat_is_3", 64'(s_bub), 64'd3);
        check("wide_is_5", 64'(bubble_cnt), 64'd5);
        clr_stat = 1;
        step("clr_with_bubble");
        check("clr_wins", 64'(s_bub), 64'd0);

        // Invalid instruction passes through with its write enables intact
        drive_pass(1'b0, 5'd31, 1'b1, 32'h7777_7777, 1'b1, 32'h8, 32'h9);
        step("pass_invalid");

        // Random mix
        for (int i = 0; i < 40; i++) begin
            flush     = ($urandom_range(0, 7) == 0);
            stall_mem = ($urandom_range(0, 3) == 0);
            stall_ex  = stall_mem ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            clr_stat  = ($urandom_range(0, 9) == 0);
            ex_valid  = 1'($urandom_range(0, 1));
            ex_wd     = 5'($urandom_range(0, 31));
            ex_wreg   = 1'($urandom_range(0, 1));
            ex_whilo  = 1'($urandom_range(0, 1));
            ex_wdata  = $urandom; ex_hi = $urandom; ex_lo = $urandom;
            ex_hilo_temp = {$urandom, $urandom};
            ex_cnt    = 2'($urandom_range(0, 3));
            step("random");
        end

        // Async reset mid-cycle during a multi-cycle op, while holding
        drive_pass(1'b1, 5'd4, 1'b1, 32'h1234_5678, 1'b1, 32'hA, 32'hB);
        step("pass_pre_rst");
        stall_ex = 1; ex_hilo_temp = 64'h0123_4567_89AB_CDEF; ex_cnt = 2'd2;
        step("bubble_pre_rst");
        stall_mem = 1;
        #3 rst = 1'b1;
        #1 expect_reset("reset_async");
        @(negedge clk);
        rst = 1'b0;
        drive_pass(1'b1, 5'd6, 1'b1, 32'hFEED_FACE, 1'b0, 32'h0, 32'h1);
        step("first_pass_after_rst");
        e0 = m;
        check("post_rst_wd", 64'(mem_wd), 64'(e0.wd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX/MEM pipeline register for the MIPS32 core. It replaces the plain EX-to-MEM register with one that responds to stall and flush requests from the pipeline controller. It also carries HI/LO write-back fields and holds the partial results of multi-cycle EX operations (madd/msub) across stall cycles. A saturating bubble counter is included for performance statistics.

## Interface
- `DATA_W`, default 32: width of register data, HI and LO.
- `ADDR_W`, default 5: width of the destination register address.
- `CNT_W`, default 2: width of the multi-cycle step counter.
- `STAT_W`, default 16: width of the bubble counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall_ex`  in  1  controller stall request for the EX stage.
- `stall_mem`  in  1  controller stall request for the MEM stage.
- `flush`  in  1  exception/branch flush; kills the stage contents.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_wd`  in  ADDR_W  destination register address.
- `ex_wreg`  in  1  GPR write enable.
- `ex_wdata`  in  DATA_W  GPR write data.
- `ex_whilo`  in  1  HI/LO write enable.
- `ex_hi`, `ex_lo`  in  DATA_W  HI/LO write data.
- `ex_hilo_temp`  in  2*DATA_W  partial product from the multi-cycle op.
- `ex_cnt`  in  CNT_W  step index of the multi-cycle op.
- `clr_stat`  in  1  synchronous clear of the bubble counter.
- `mem_valid`, `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_whilo`, `mem_hi`, `mem_lo`  out  as the matching `ex_*` inputs  registered MEM-side fields.
- `hilo_temp_o`  out  2*DATA_W  held partial product, fed back to EX.
- `cnt_o`  out  CNT_W  held step index, fed back to EX.
- `bubble_cnt`  out  STAT_W  number of bubbles inserted, saturating.

## Operation
- Reset value of every output is 0 (`mem_wd` = NOP address 0; write enables disabled).
- Each cycle exactly one action applies, chosen in this priority order:
  1. **FLUSH** (`flush`=1): MEM fields are set to the bubble value (valid, wreg, whilo=0; wd, data, hi, lo=0). `hilo_temp_o` and `cnt_o` are set to 0.
  2. **HOLD** (`stall_mem`=1): all MEM fields and feedback registers keep their values. This applies whatever the value of `stall_ex`. The combination `!stall_ex && stall_mem` is never issued by the controller; if it occurs, it is treated as HOLD.
  3. **BUBBLE** (`stall_ex`=1, `stall_mem`=0): MEM fields are set to the bubble value. `hilo_temp_o` captures `ex_hilo_temp` and `cnt_o` captures `ex_cnt`, so the multi-cycle op keeps its partial result.
  4. **PASS** (no stall): all `ex_*` fields are captured into `mem_*`. `hilo_temp_o` and `cnt_o` are set to 0.
- Bubble counter:
  - Increments by 1 in every BUBBLE cycle.
  - FLUSH does not count as a bubble.
  - Saturates at 2^STAT_W-1.
  - `clr_stat` sets it to 0 and takes precedence over an increment in the same cycle.
  - The counter is not affected by `flush`.
- `ex_valid`=0 in a PASS cycle is captured as-is; the register does not gate the write enables. The `mem_*` write enables are forced to 0 only in bubble/flush cycles.
- There is no arithmetic on the datapath; all fields are copied at full width.

## Timing
- Latency is 1 cycle: `ex_*` sampled at edge N appear on `mem_*` after edge N.
- `rst` clears all state immediately, without waiting for a clock edge. The first PASS is the first rising edge after `rst` is deasserted.
- Reset asserted in the middle of a multi-cycle op discards `hilo_temp_o` and `cnt_o`.
- Feedback timing: `hilo_temp_o` and `cnt_o` are valid in the cycle after a BUBBLE, so EX can finish the next step.

## Structure
- The shared package `cpu_defs` holds:
  - the bubble constants (`ZeroWord`, `NOPRegAddr`, `WriteDisable`);
  - an enum of the four actions (FLUSH/HOLD/BUBBLE/PASS).
- One sub-module is natural: `sat_counter` (parameter width; increment, clear, saturation), used for `bubble_cnt`.
- The action decode is a single combinational priority encoder inside `ex_mem_pipe`.

## Test plan
- **Reset**: assert `rst` asynchronously mid-cycle while data is held -> all outputs read 0 before the next edge; `bubble_cnt`=0.
- **PASS**: `ex_wd`=5'd3, `ex_wreg`=1, `ex_wdata`=32'hDEADBEEF, `ex_whilo`=1, `ex_hi`=32'h1, `ex_lo`=32'h2 -> identical values on `mem_*` one cycle later.
- **BUBBLE for madd**: `stall_ex`=1 for 2 cycles with `ex_hilo_temp`=64'h0000_0001_0000_0002, `ex_cnt`=1 ->
  - `mem_wreg`=0 and `mem_valid`=0;
  - `hilo_temp_o`=that value and `cnt_o`=1;
  - `bubble_cnt`=2;
  - on the next PASS, `cnt_o` returns to 0.
- **HOLD**: PASS loads `mem_wdata`=32'hA5A5A5A5, then `stall_ex`=`stall_mem`=1 for 3 cycles with different inputs -> outputs stay at A5A5A5A5; `bubble_cnt` is unchanged.
- **FLUSH priority**: `flush`=1 together with `stall_ex`=1 and `stall_mem`=0 -> bubble outputs, `cnt_o`=0, `bubble_cnt` not incremented.
- **Saturation**: with `STAT_W`=2, 5 consecutive BUBBLE cycles -> `bubble_cnt`=3. Then `clr_stat` together with a BUBBLE -> `bubble_cnt`=0.
